audio_cycle_ctrl: RTL and testbench
===================================

// Module: audio_cycle_ctrl
// PURPOSE
//  Bus master that sequences the 4-register stereo sample mux for one jack cycle.
//  On start it writes the buffer size (addr 3) and sets the read-active flag (addr 2).
//  On each trig rising edge it reads L (addr 0), then R (addr 1), and presents the pair
//  on a valid/ready stream. At cycle end it clears the read-active flag (addr 2).
// PARAMETERS
//  FIFO_WIDTH  6   frame-count and buffer-size field is FIFO_WIDTH+1 bits (matches mux addr 3)
// PORTS
//  clk          in   1    system clock; all logic on posedge
//  reset        in   1    synchronous, active-high
//  start        in   1    pulse: begin cycle; ignored unless busy=0
//  stop         in   1    pulse: end free-running cycle after the current frame
//  frames_cfg   in   FW+1 frames per cycle, sampled on start; 0 = free-run until stop
//  trig         in   1    frame request from mux (level); rising edge = 1 request
//  address      out  2    mux register address
//  read         out  1    mux read strobe, 1 clk
//  write        out  1    mux write strobe, 1 clk
//  datain       out  32   mux write data
//  dataout      in   32   mux read data; sample in [31:8]; valid the clk after read
//  l_sample     out  24   left sample of the presented pair
//  r_sample     out  24   right sample of the presented pair
//  sample_valid out  1    pair valid; held with data stable until sample_ready
//  sample_ready in   1    consumer accept; transfer when valid&&ready
//  busy         out  1    1 in every state except IDLE
//  done         out  1    1-clk pulse on the END -> IDLE transition
//  overrun      out  1    sticky; a trig edge was lost; cleared by start or reset
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; frame cnt=0; pending=0. No addr-2 clear write is issued.
//  trig_q <= trig. Edge = trig && !trig_q. Edge outside WAIT_TRIG: pending<=1 (one deep).
//   If pending is already 1, the edge is dropped and overrun<=1.
//  FSM, one clk per state unless stated:
//   IDLE     : start -> CFG_SIZE; latch frames_cfg; cnt<=0; overrun<=0; pending<=0.
//   CFG_SIZE : write=1, address=3, datain={0,frames_cfg} -> CFG_ACT.
//   CFG_ACT  : write=1, address=2, datain=1 -> WAIT_TRIG.
//   WAIT_TRIG: stop_req -> END. Else edge or pending -> RD_L; pending<=0. Else wait.
//   RD_L     : read=1, address=0 -> CAP_L.
//   CAP_L    : l_hold <= dataout[31:8] -> RD_R.
//   RD_R     : read=1, address=1 -> CAP_R.
//   CAP_R    : r_hold <= dataout[31:8] -> PUSH.
//   PUSH     : wait until sample_valid=0 or (valid&&ready), then load l/r_sample and
//              set valid=1; cnt<=cnt+1; next = END if cnt+1==frames or stop_req,
//              else WAIT_TRIG.
//   END      : write=1, address=2, datain=0; done=1; stop_req<=0 -> IDLE.
//  stop pulse while busy: stop_req<=1, honoured only at PUSH or WAIT_TRIG.
//   Frames are never truncated.
//  cnt is FIFO_WIDTH+1 bits. frames=0 never matches (cnt wraps 2^(FW+1)-1 -> 0).
//  Latency: trig edge in WAIT_TRIG -> sample_valid=1 five clks later (if not stalled).
//  sample_valid clears on valid&&ready unless PUSH reloads in the same clk.
//   Pair beats are back-to-back; no bubble.
//  read and write are never both 1. address holds its last value when idle.
//  start while busy is ignored. Reset mid-cycle: immediate IDLE.
// CONFIGURATION
//  AUDIO_CYCLE_CTRL_PEAK_EN defined:
//   Adds outputs l_peak[22:0] and r_peak[22:0].
//   Each holds the max |sample| seen since start (saturating: -2^23 -> 2^23-1 before cmp).
//   Updated in CAP_L/CAP_R. Cleared on reset and on start.
//  Not defined: no peak ports and no peak logic.
// TESTING
//  1 start, frames_cfg=3, 3 trig edges, ready=1 -> writes (3,3),(2,1); 3 pairs L/R
//    match mux; then write (2,0), done=1 once, busy=0.
//  2 frames_cfg=0, 5 trig edges, stop after 2nd pair -> 3rd pair still delivered
//    if its read started; end write (2,0); done pulse.
//  3 ready=0 held 20 clks, 2 trig edges -> 1st pair held stable; FSM waits in PUSH;
//    pair 2 appears the clk after 1st accept.
//  4 3 trig edges during one read burst -> 1 pending served; overrun=1 sticky
//    until next start.
//  5 reset asserted in RD_R -> next clk all outputs 0, IDLE, no writes;
//    start works normally after.
//  6 PEAK_EN: L samples 0x000010, 0xFFFF00, 0x800000 -> l_peak=0x7FFFFF; start clears to 0.

Source files
------------

// File: rtl/audio_cycle_ctrl.sv
// audio_cycle_ctrl: bus master sequencing one jack cycle on the 4-register stereo sample mux.
// Define AUDIO_CYCLE_CTRL_PEAK_EN to add l_peak/r_peak magnitude tracking outputs.
module audio_cycle_ctrl #(
  parameter int unsigned FIFO_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [FIFO_WIDTH:0]   frames_cfg,
  input  logic                  trig,
  output logic [1:0]            address,
  output logic                  read,
  output logic                  write,
  output logic [31:0]           datain,
  input  logic [31:0]           dataout,
  output logic [23:0]           l_sample,
  output logic [23:0]           r_sample,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
`ifdef AUDIO_CYCLE_CTRL_PEAK_EN
  ,
  output logic [22:0]           l_peak,
  output logic [22:0]           r_peak
`endif
);

  localparam int unsigned CW = FIFO_WIDTH + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG_SIZE,
    S_CFG_ACT,
    S_WAIT_TRIG,
    S_RD_L,
    S_CAP_L,
    S_RD_R,
    S_CAP_R,
    S_PUSH,
    S_END
  } state_t;

  state_t          state, state_nxt;
  logic            trig_q;
  logic            pending;
  logic            stop_req;
  logic [CW-1:0]   frames_q;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic [23:0]     l_hold;
  logic [23:0]     r_hold;
  logic            trig_edge;
  logic            push_go;
  logic            last_frame;
  logic            cycle_start;
  logic            rd_nxt;
  logic            wr_nxt;
  logic [1:0]      addr_nxt;
  logic [31:0]     data_nxt;
  logic            unused_dout;

  assign unused_dout = ^dataout[7:0];
  assign trig_edge   = trig && !trig_q;
  assign push_go     = !sample_valid || sample_ready;
  assign cnt_inc     = cnt + CW'(1);
  // frames_q == 0 means free-run, so the wrapped count must never match it
  assign last_frame  = (frames_q != '0) && (cnt_inc == frames_q);
  assign cycle_start = (state == S_IDLE) && start;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_CFG_SIZE;
      S_CFG_SIZE:  state_nxt = S_CFG_ACT;
      S_CFG_ACT:   state_nxt = S_WAIT_TRIG;
      S_WAIT_TRIG: begin
        if (stop_req)                  state_nxt = S_END;
        else if (trig_edge || pending) state_nxt = S_RD_L;
      end
      S_RD_L:      state_nxt = S_CAP_L;
      S_CAP_L:     state_nxt = S_RD_R;
      S_RD_R:      state_nxt = S_CAP_R;
      S_CAP_R:     state_nxt = S_PUSH;
      S_PUSH: begin
        if (push_go) state_nxt = (last_frame || stop_req) ? S_END : S_WAIT_TRIG;
      end
      S_END:       state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Bus strobes are registered from the next state so they are active for exactly the
  // state's cycle; CFG_SIZE is only entered from IDLE, hence frames_cfg rather than frames_q.
  always_comb begin
    rd_nxt   = 1'b0;
    wr_nxt   = 1'b0;
    addr_nxt = address;
    data_nxt = datain;
    case (state_nxt)
      S_CFG_SIZE: begin wr_nxt = 1'b1; addr_nxt = 2'd3; data_nxt = 32'(frames_cfg); end
      S_CFG_ACT:  begin wr_nxt = 1'b1; addr_nxt = 2'd2; data_nxt = 32'd1; end
      S_RD_L:     begin rd_nxt = 1'b1; addr_nxt = 2'd0; end
      S_RD_R:     begin rd_nxt = 1'b1; addr_nxt = 2'd1; end
      S_END:      begin wr_nxt = 1'b1; addr_nxt = 2'd2; data_nxt = 32'd0; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      trig_q       <= 1'b0;
      pending      <= 1'b0;
      stop_req     <= 1'b0;
      overrun      <= 1'b0;
      frames_q     <= '0;
      cnt          <= '0;
      l_hold       <= '0;
      r_hold       <= '0;
      address      <= '0;
      read         <= 1'b0;
      write        <= 1'b0;
      datain       <= '0;
      l_sample     <= '0;
      r_sample     <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state   <= state_nxt;
      trig_q  <= trig;
      address <= addr_nxt;
      read    <= rd_nxt;
      write   <= wr_nxt;
      datain  <= data_nxt;
      busy    <= (state_nxt != S_IDLE);
      done    <= (state_nxt == S_END);

      if (cycle_start) begin
        frames_q <= frames_cfg;
        cnt      <= '0;
      end

      if (cycle_start || state == S_END) stop_req <= 1'b0;
      else if (stop && state != S_IDLE)  stop_req <= 1'b1;

      // One-deep request memory for edges that arrive while the FSM is not waiting
      if (cycle_start) begin
        pending <= 1'b0;
        overrun <= 1'b0;
      end else if (trig_edge && state != S_WAIT_TRIG) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end else if (state == S_WAIT_TRIG && !stop_req && (trig_edge || pending)) begin
        pending <= 1'b0;
      end

      if (state == S_CAP_L) l_hold <= dataout[31:8];
      if (state == S_CAP_R) r_hold <= dataout[31:8];

      if (state == S_PUSH && push_go) begin
        l_sample     <= l_hold;
        r_sample     <= r_hold;
        sample_valid <= 1'b1;
        cnt          <= cnt_inc;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

`ifdef AUDIO_CYCLE_CTRL_PEAK_EN
  function automatic logic [22:0] sat_mag(input logic [23:0] s);
    logic [23:0] neg;
    neg = -s;
    if (!s[23])              return s[22:0];
    else if (s == 24'h800000) return '1;
    else                      return neg[22:0];
  endfunction

  logic [22:0] in_mag;
  assign in_mag = sat_mag(dataout[31:8]);

  always_ff @(posedge clk) begin
    if (reset || cycle_start) begin
      l_peak <= '0;
      r_peak <= '0;
    end else begin
      if (state == S_CAP_L && in_mag > l_peak) l_peak <= in_mag;
      if (state == S_CAP_R && in_mag > r_peak) r_peak <= in_mag;
    end
  end
`else
  // Peak tracking not built: no additional state.
`endif

endmodule

// File: tb/tb_audio_cycle_ctrl.sv
// Self-checking bench for audio_cycle_ctrl: random mux data, directed cycle scenarios.
// Define AUDIO_CYCLE_CTRL_PEAK_EN to also exercise the peak outputs.
module tb_audio_cycle_ctrl;
  localparam int FW = 6;

  logic          clk = 1'b0;
  logic          reset, start, stop, trig, sample_ready;
  logic [FW:0]   frames_cfg;
  logic [1:0]    address;
  logic          read, write, sample_valid, busy, done, overrun;
  logic [31:0]   datain;
  logic [31:0]   dataout = '0;
  logic [23:0]   l_sample, r_sample;
`ifdef AUDIO_CYCLE_CTRL_PEAK_EN
  logic [22:0]   l_peak, r_peak;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [23:0] exp_l[$], exp_r[$], got_l[$], got_r[$], force_l[$];
  logic [33:0] wr_log[$];

  audio_cycle_ctrl #(.FIFO_WIDTH(FW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .frames_cfg(frames_cfg),
    .trig(trig), .address(address), .read(read), .write(write), .datain(datain),
    .dataout(dataout), .l_sample(l_sample), .r_sample(r_sample),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .busy(busy),
    .done(done), .overrun(overrun)
`ifdef AUDIO_CYCLE_CTRL_PEAK_EN
    , .l_peak(l_peak), .r_peak(r_peak)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Mux register file: L/R registers return fresh random samples on every read
  always @(posedge clk) begin : mux_model
    logic [31:0] v;
    v = $urandom();
    if (read) begin
      if (address == 2'd0) begin
        if (force_l.size() > 0) begin
          v[31:8] = force_l.pop_front();
        end
        exp_l.push_back(v[31:8]);
      end else if (address == 2'd1) begin
        exp_r.push_back(v[31:8]);
      end else begin
        v = 32'hDEADBEEF;
      end
      dataout <= v;
    end
  end

  always @(negedge clk) begin
    if (write) wr_log.push_back({address, datain});
    if (sample_valid && sample_ready) begin
      got_l.push_back(l_sample);
      got_r.push_back(r_sample);
    end
    if (done) done_cnt++;
    if (read || write) check("rd_wr_excl", 64'(read & write), 64'd0);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    exp_l.delete(); exp_r.delete(); got_l.delete(); got_r.delete(); wr_log.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [FW:0] f);
    frames_cfg = f;
    start = 1'b1;
    step();
    start = 1'b0;
    step(2);
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    step();
    trig = 1'b0;
    step();
  endtask

  task automatic wait_pairs(input string tag, input int n, input bit rnd);
    int k = 0;
    while (got_l.size() < n && k < 200) begin
      if (rnd) sample_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    check({tag, "_pair_timeout"}, 64'(got_l.size() >= n), 64'd1);
  endtask

  task automatic wait_idle(input string tag, input bit rnd);
    int k = 0;
    while (busy && k < 200) begin
      if (rnd) sample_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    sample_ready = 1'b1;
    check({tag, "_idle_timeout"}, 64'(busy), 64'd0);
  endtask

  task automatic compare_pairs(input string tag, input int n);
    check({tag, "_npairs"}, 64'(got_l.size()), 64'(n));
    check({tag, "_nreads"}, 64'(exp_r.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got_l.size() && i < exp_l.size() && i < exp_r.size()) begin
        check({tag, "_l"}, 64'(got_l[i]), 64'(exp_l[i]));
        check({tag, "_r"}, 64'(got_r[i]), 64'(exp_r[i]));
      end
    end
  endtask

  task automatic compare_cycle(input string tag, input logic [FW:0] f);
    logic [33:0] e[3];
    e[0] = {2'd3, 32'(f)};
    e[1] = {2'd2, 32'd1};
    e[2] = {2'd2, 32'd0};
    check({tag, "_nwrites"}, 64'(wr_log.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_log.size()) check({tag, "_write"}, 64'(wr_log[i]), 64'(e[i]));
    end
    check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    check({tag, "_valid_low"}, 64'(sample_valid), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_address"}, 64'(address), 64'd0);
    check({tag, "_read"}, 64'(read), 64'd0);
    check({tag, "_write"}, 64'(write), 64'd0);
    check({tag, "_datain"}, 64'(datain), 64'd0);
    check({tag, "_l_sample"}, 64'(l_sample), 64'd0);
    check({tag, "_r_sample"}, 64'(r_sample), 64'd0);
    check({tag, "_valid"}, 64'(sample_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_overrun"}, 64'(overrun), 64'd0);
  endtask

`ifdef AUDIO_CYCLE_CTRL_PEAK_EN
  function automatic logic [22:0] peak_of(input logic [23:0] q[$]);
    int m = 0;
    foreach (q[i]) begin
      int v;
      v = int'(signed'(q[i]));
      if (v < 0) v = -v;
      if (v > 8388607) v = 8388607;
      if (v > m) m = v;
    end
    return 23'(m);
  endfunction
`endif

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int lat;
    int wr_before;
    logic [FW:0] f;

    reset = 1'b1; start = 1'b0; stop = 1'b0; trig = 1'b0;
    frames_cfg = '0; sample_ready = 1'b1;
    step(3);
    check_outputs_zero("reset");
    reset = 1'b0;
    step();

    // 1: fixed-length cycle, 3 frames, consumer always ready, trig->valid latency
    clear_logs();
    do_start(7'd3);
    trig = 1'b1;
    step();
    trig = 1'b0;
    lat = 1;
    while (!sample_valid && lat < 20) begin
      step();
      lat++;
    end
    check("t1_latency", 64'(lat), 64'd6);
    wait_pairs("t1", 1, 1'b0);
    for (int k = 2; k <= 3; k++) begin
      pulse_trig();
      wait_pairs("t1", k, 1'b0);
    end
    wait_idle("t1", 1'b0);
    compare_pairs("t1", 3);
    compare_cycle("t1", 7'd3);

    // 2: free-run, stop during the third frame's read; that frame still completes
    clear_logs();
    do_start(7'd0);
    for (int k = 1; k <= 2; k++) begin
      pulse_trig();
      wait_pairs("t2", k, 1'b0);
    end
    trig = 1'b1;
    step();
    check("t2_rd_l", 64'({read, address}), 64'(3'b100));
    trig = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    pulse_trig();
    pulse_trig();
    wait_idle("t2", 1'b0);
    compare_pairs("t2", 3);
    compare_cycle("t2", 7'd0);

    // 3: consumer stalls 20 clks; first pair holds, second follows right after accept
    clear_logs();
    sample_ready = 1'b0;
    do_start(7'd2);
    pulse_trig();
    lat = 0;
    while (!sample_valid && lat < 20) begin
      step();
      lat++;
    end
    for (int i = 0; i < 20; i++) begin
      check("t3_hold_valid", 64'(sample_valid), 64'd1);
      check("t3_hold_l", 64'(l_sample), 64'((exp_l.size() > 0) ? exp_l[0] : 24'hx));
      check("t3_hold_r", 64'(r_sample), 64'((exp_r.size() > 0) ? exp_r[0] : 24'hx));
      if (i == 2) trig = 1'b1;
      if (i == 3) trig = 1'b0;
      step();
    end
    sample_ready = 1'b1;
    step();
    check("t3_next_valid", 64'(sample_valid), 64'd1);
    check("t3_next_l", 64'(l_sample), 64'((exp_l.size() > 1) ? exp_l[1] : 24'hx));
    check("t3_next_r", 64'(r_sample), 64'((exp_r.size() > 1) ? exp_r[1] : 24'hx));
    wait_idle("t3", 1'b0);
    compare_pairs("t3", 2);
    compare_cycle("t3", 7'd2);

    // 4: three edges within one read burst: one pending served, one lost
    clear_logs();
    do_start(7'd2);
    check("t4_overrun_init", 64'(overrun), 64'd0);
    for (int k = 0; k < 3; k++) pulse_trig();
    wait_idle("t4", 1'b0);
    compare_pairs("t4", 2);
    compare_cycle("t4", 7'd2);
    check("t4_overrun", 64'(overrun), 64'd1);
    step(5);
    check("t4_overrun_sticky", 64'(overrun), 64'd1);

    // 5: reset during the R read aborts the cycle silently; start works afterwards
    clear_logs();
    do_start(7'd1);
    check("t5_overrun_cleared", 64'(overrun), 64'd0);
    trig = 1'b1;
    step();
    trig = 1'b0;
    lat = 0;
    while (!(read && address == 2'd1) && lat < 20) begin
      step();
      lat++;
    end
    check("t5_in_rd_r", 64'({read, address}), 64'(3'b101));
    wr_before = wr_log.size();
    reset = 1'b1;
    step();
    check_outputs_zero("t5_reset");
    step();
    reset = 1'b0;
    step(3);
    check("t5_no_writes", 64'(wr_log.size()), 64'(wr_before));
    clear_logs();
    do_start(7'd1);
    pulse_trig();
    wait_idle("t5", 1'b0);
    compare_pairs("t5", 1);
    compare_cycle("t5", 7'd1);

    // 5b: stop while waiting for the first trig ends the cycle with no frames
    clear_logs();
    do_start(7'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle("t5b", 1'b0);
    compare_pairs("t5b", 0);
    compare_cycle("t5b", 7'd0);

    // 7: random frame counts with a randomly stalling consumer
    for (int rep = 0; rep < 3; rep++) begin
      f = 7'($urandom_range(3, 6));
      clear_logs();
      do_start(f);
      for (int k = 1; k <= int'(f); k++) begin
        pulse_trig();
        wait_pairs("t7", k, 1'b1);
      end
      wait_idle("t7", 1'b1);
      compare_pairs("t7", int'(f));
      compare_cycle("t7", f);
    end

`ifdef AUDIO_CYCLE_CTRL_PEAK_EN
    // 6: saturating peak magnitude, cleared by the next start
    clear_logs();
    force_l.push_back(24'h000010);
    force_l.push_back(24'hFFFF00);
    force_l.push_back(24'h800000);
    do_start(7'd3);
    check("t6_peak_start", 64'({l_peak, r_peak}), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      pulse_trig();
      wait_pairs("t6", k, 1'b0);
    end
    wait_idle("t6", 1'b0);
    compare_pairs("t6", 3);
    check("t6_l_peak", 64'(l_peak), 64'(23'h7FFFFF));
    check("t6_r_peak", 64'(r_peak), 64'(peak_of(exp_r)));
    clear_logs();
    do_start(7'd0);
    check("t6_l_peak_clr", 64'(l_peak), 64'd0);
    check("t6_r_peak_clr", 64'(r_peak), 64'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle("t6b", 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
